// File: rtl/ahb_bridge_pkg.sv
// Shared encodings for the AHB-to-APB bridge: HTRANS, HRESP and the error-response FSM states.
// Also holds small helpers used by the error-response path.
package ahb_bridge_pkg;

    localparam int ADDR_W    = 32;
    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_ERR1  = 3'd2,
        ST_ERR2  = 3'd3,
        ST_FLUSH = 3'd4
    } err_state_e;

    // True while the master is still inside the burst that took the error.
    function automatic logic burst_continues(input htrans_e trans);
        return (trans == HTRANS_SEQ) || (trans == HTRANS_BUSY);
    endfunction

    // True when the master has left the burst (new transfer or idle).
    function automatic logic burst_left(input htrans_e trans);
        return (trans == HTRANS_IDLE) || (trans == HTRANS_NONSEQ);
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/err_log.sv
// Error log: captures the address of the latest errored transfer and a saturating error count.
// Clear has priority over a coincident load.
module err_log
    import ahb_bridge_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic                 clr_i,
    input  logic [ADDR_W-1:0]    addr_i,
    output logic [ADDR_W-1:0]    err_addr_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [ERR_CNT_W-1:0] cnt_q,  cnt_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            addr_d = '0;
            cnt_d  = '0;
        end else if (load_i) begin
            addr_d = addr_i;
            cnt_d  = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign err_addr_o = addr_q;
    assign err_cnt_o  = cnt_q;

endmodule

// File: rtl/ahb_err_resp.sv
// AHB two-cycle ERROR response generator for burst-protocol violations, with burst flush
// and an error log. Outputs decode from the registered state (IDLE HREADYOUT follows apb_ready).
module ahb_err_resp
    import ahb_bridge_pkg::*;
(
    input  logic                 h_clk,
    input  logic                 h_resetn,
    input  logic                 burst_err,
    input  logic [1:0]           h_trans,
    input  logic                 h_ready,
    input  logic [ADDR_W-1:0]    reg_addr,
    input  logic                 apb_ready,
    input  logic                 err_clr,
    output logic                 h_readyout,
    output logic                 h_resp,
    output logic                 abort,
    output logic [ADDR_W-1:0]    err_addr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    err_state_e state_q, state_d;
    htrans_e    trans;
    hresp_e     resp;
    logic       log_load;

    assign trans = htrans_e'(h_trans);

    always_ff @(posedge h_clk or negedge h_resetn) begin
        if (!h_resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // burst_err is only looked at in IDLE and FLUSH; a held flag cannot queue a second response.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (burst_err) begin
                    state_d = apb_ready ? ST_ERR1 : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (apb_ready) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                state_d = burst_continues(trans) ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                if (burst_err) begin
                    state_d = ST_ERR1;
                end else if (h_ready && burst_left(trans)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        h_readyout = 1'b1;
        resp       = HRESP_OKAY;
        abort      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                h_readyout = apb_ready;
            end
            ST_HOLD: begin
                h_readyout = 1'b0;
            end
            ST_ERR1: begin
                h_readyout = 1'b0;
                resp       = HRESP_ERROR;
                abort      = 1'b1;
            end
            ST_ERR2: begin
                resp       = HRESP_ERROR;
                abort      = 1'b1;
            end
            ST_FLUSH: begin
                abort      = 1'b1;
            end
            default: begin
                h_readyout = apb_ready;
            end
        endcase
    end

    assign h_resp = resp;

    // Log on the edge that enters ERR1; ERR1 never loops on itself so this is a single strobe.
    assign log_load = (state_d == ST_ERR1) && (state_q != ST_ERR1);

    err_log u_err_log (
        .clk_i      (h_clk),
        .rst_ni     (h_resetn),
        .load_i     (log_load),
        .clr_i      (err_clr),
        .addr_i     (reg_addr),
        .err_addr_o (err_addr),
        .err_cnt_o  (err_cnt)
    );

endmodule

// File: tb/tb_ahb_err_resp.sv
// Directed bench for ahb_err_resp: reset, basic/HOLD/flush responses, saturation, clear and reset abort.
module tb_ahb_err_resp;

    logic        h_clk;
    logic        h_resetn;
    logic        burst_err;
    logic [1:0]  h_trans;
    logic        h_ready;
    logic [31:0] reg_addr;
    logic        apb_ready;
    logic        err_clr;
    logic        h_readyout;
    logic        h_resp;
    logic        abort;
    logic [31:0] err_addr;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    ahb_err_resp dut (
        .h_clk      (h_clk),
        .h_resetn   (h_resetn),
        .burst_err  (burst_err),
        .h_trans    (h_trans),
        .h_ready    (h_ready),
        .reg_addr   (reg_addr),
        .apb_ready  (apb_ready),
        .err_clr    (err_clr),
        .h_readyout (h_readyout),
        .h_resp     (h_resp),
        .abort      (abort),
        .err_addr   (err_addr),
        .err_cnt    (err_cnt)
    );

    initial h_clk = 1'b0;
    always #5 h_clk = ~h_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the three handshake outputs together.
    task automatic chk_out(input string tag, input logic rdy, input logic rsp, input logic abt);
        chk({tag, ".readyout"}, {31'd0, h_readyout}, {31'd0, rdy});
        chk({tag, ".resp"},     {31'd0, h_resp},     {31'd0, rsp});
        chk({tag, ".abort"},    {31'd0, abort},      {31'd0, abt});
        $display("step %s: readyout=%0b resp=%0b abort=%0b cnt=%0d addr=%h",
                 tag, h_readyout, h_resp, abort, err_cnt, err_addr);
    endtask

    task automatic tick();
        @(posedge h_clk);
        #1;
    endtask

    initial begin
        h_resetn  = 1'b0;
        burst_err = 1'b0;
        h_trans   = 2'b00;
        h_ready   = 1'b1;
        reg_addr  = 32'h0;
        apb_ready = 1'b1;
        err_clr   = 1'b0;

        // During reset: readyout follows apb_ready, no error, log empty
        #2;
        chk_out("rst_rdy1", 1'b1, 1'b0, 1'b0);
        apb_ready = 1'b0;
        #1;
        chk_out("rst_rdy0", 1'b0, 1'b0, 1'b0);
        chk("rst_cnt",  {24'd0, err_cnt}, 32'd0);
        chk("rst_addr", err_addr, 32'd0);
        apb_ready = 1'b1;
        tick();
        tick();
        h_resetn = 1'b1;

        // 1) single pulse in IDLE with apb_ready=1
        reg_addr  = 32'h0000_00A0;
        burst_err = 1'b1;
        tick();
        burst_err = 1'b0;
        chk_out("s1_err1", 1'b0, 1'b1, 1'b1);
        chk("s1_cnt",  {24'd0, err_cnt}, 32'd1);
        chk("s1_addr", err_addr, 32'h0000_00A0);
        tick();
        chk_out("s1_err2", 1'b1, 1'b1, 1'b1);
        tick();
        chk_out("s1_idle", 1'b1, 1'b0, 1'b0);

        // 2) error while APB busy: three HOLD cycles then response
        apb_ready = 1'b0;
        burst_err = 1'b1;
        reg_addr  = 32'h0000_00B0;
        tick();
        burst_err = 1'b0;
        chk_out("s2_hold1", 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("s2_hold2", 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("s2_hold3", 1'b0, 1'b0, 1'b0);
        chk("s2_cnt_hold", {24'd0, err_cnt}, 32'd1);
        apb_ready = 1'b1;
        tick();
        chk_out("s2_err1", 1'b0, 1'b1, 1'b1);
        chk("s2_cnt", {24'd0, err_cnt}, 32'd2);
        tick();
        chk_out("s2_err2", 1'b1, 1'b1, 1'b1);
        tick();
        chk_out("s2_idle", 1'b1, 1'b0, 1'b0);

        // 3) INCR4 error on beat 2, master continues with SEQ -> flush
        h_trans   = 2'b11;
        reg_addr  = 32'h0000_1004;
        burst_err = 1'b1;
        tick();
        burst_err = 1'b0;
        reg_addr  = 32'h0000_1008;
        chk_out("s3_err1", 1'b0, 1'b1, 1'b1);
        chk("s3_addr", err_addr, 32'h0000_1004);
        tick();
        chk_out("s3_err2", 1'b1, 1'b1, 1'b1);
        tick();
        chk_out("s3_flush1", 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("s3_flush2", 1'b1, 1'b0, 1'b1);
        h_trans = 2'b10;
        h_ready = 1'b0;
        tick();
        chk_out("s3_flush_nordy", 1'b1, 1'b0, 1'b1);
        h_ready = 1'b1;
        tick();
        chk_out("s3_idle", 1'b1, 1'b0, 1'b0);
        chk("s3_cnt",   {24'd0, err_cnt}, 32'd3);
        chk("s3_addr2", err_addr, 32'h0000_1004);

        // 5) burst_err held through ERR1 and ERR2: exactly one response
        h_trans   = 2'b00;
        reg_addr  = 32'h0000_2000;
        burst_err = 1'b1;
        tick();
        chk_out("s5_err1", 1'b0, 1'b1, 1'b1);
        tick();
        chk_out("s5_err2", 1'b1, 1'b1, 1'b1);
        tick();
        burst_err = 1'b0;
        chk_out("s5_idle", 1'b1, 1'b0, 1'b0);
        chk("s5_cnt", {24'd0, err_cnt}, 32'd4);
        tick();
        chk_out("s5_idle2", 1'b1, 1'b0, 1'b0);

        // 6) burst_err in FLUSH beats the NONSEQ exit and re-enters ERR1
        h_trans   = 2'b11;
        reg_addr  = 32'h0000_3000;
        burst_err = 1'b1;
        tick();
        burst_err = 1'b0;
        tick();
        tick();
        chk_out("s6_flush", 1'b1, 1'b0, 1'b1);
        chk("s6_cnt_a", {24'd0, err_cnt}, 32'd5);
        burst_err = 1'b1;
        h_trans   = 2'b10;
        reg_addr  = 32'h0000_3008;
        tick();
        burst_err = 1'b0;
        h_trans   = 2'b00;
        chk_out("s6_err1", 1'b0, 1'b1, 1'b1);
        chk("s6_cnt_b", {24'd0, err_cnt}, 32'd6);
        chk("s6_addr",  err_addr, 32'h0000_3008);
        tick();
        tick();
        chk_out("s6_idle", 1'b1, 1'b0, 1'b0);

        // 4) clear, then 256 pulses saturate at FF; clear beats a coincident load
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("s4_clr_cnt",  {24'd0, err_cnt}, 32'd0);
        chk("s4_clr_addr", err_addr, 32'd0);
        reg_addr = 32'h0000_4000;
        for (int i = 0; i < 254; i++) begin
            burst_err = 1'b1;
            tick();
            burst_err = 1'b0;
            tick();
            tick();
        end
        chk("s4_cnt254", {24'd0, err_cnt}, 32'd254);
        for (int i = 0; i < 2; i++) begin
            burst_err = 1'b1;
            tick();
            burst_err = 1'b0;
            chk("s4_cnt_sat", {24'd0, err_cnt}, 32'h0000_00FF);
            tick();
            tick();
        end
        burst_err = 1'b1;
        err_clr   = 1'b1;
        tick();
        burst_err = 1'b0;
        err_clr   = 1'b0;
        chk_out("s4_clr_err1", 1'b0, 1'b1, 1'b1);
        chk("s4_clr_win_cnt",  {24'd0, err_cnt}, 32'd0);
        chk("s4_clr_win_addr", err_addr, 32'd0);
        tick();
        tick();
        chk_out("s4_idle", 1'b1, 1'b0, 1'b0);

        // 7) reset dropped mid-ERR1 abandons the response at once
        reg_addr  = 32'h0000_5000;
        burst_err = 1'b1;
        tick();
        burst_err = 1'b0;
        chk_out("s7_err1", 1'b0, 1'b1, 1'b1);
        chk("s7_cnt_pre", {24'd0, err_cnt}, 32'd1);
        #2;
        h_resetn = 1'b0;
        #1;
        chk_out("s7_rst", 1'b1, 1'b0, 1'b0);
        chk("s7_cnt_rst", {24'd0, err_cnt}, 32'd0);
        tick();
        h_resetn = 1'b1;
        tick();
        chk_out("s7_after1", 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("s7_after2", 1'b1, 1'b0, 1'b0);
        chk("s7_cnt", {24'd0, err_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_err_resp.md
AHB_ERR_RESP -- requirements
Module: ahb_err_resp

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named h_clk and h_resetn.
REQ-002 Ports SHALL be as follows:
- h_clk  in  1  bridge clock.
- h_resetn  in  1  async active-low reset.
- burst_err  in  1  registered burst-protocol error flag from the burst checker.
- h_trans  in  2  AHB HTRANS, encoded IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- h_ready  in  1  AHB HREADY (bus-level).
- reg_addr  in  32  data-phase address register of the bridge.
- apb_ready  in  1  normal-path HREADYOUT from the APB FSM.
- err_clr  in  1  synchronous clear for the error log.
- h_readyout  out  1  HREADYOUT to the AHB.
- h_resp  out  1  HRESP (0=OKAY, 1=ERROR).
- abort  out  1  instructs the APB FSM to drop the pending transfer and issue no PSEL.
- err_addr  out  32  address of the most recent errored transfer.
- err_cnt  out  8  saturating count of error responses.

Function
REQ-003 The FSM SHALL have the states IDLE, HOLD, ERR1, ERR2 and FLUSH.
REQ-004 In IDLE, the block SHALL drive h_readyout=apb_ready, h_resp=0 and abort=0.
REQ-005 In IDLE, burst_err=1 with apb_ready=1 SHALL transition to ERR1; burst_err=1 with apb_ready=0 SHALL transition to HOLD.
REQ-006 In HOLD, the block SHALL drive h_readyout=0, h_resp=0 and abort=0; it SHALL stay in HOLD until apb_ready=1, then go to ERR1.
REQ-007 In ERR1, the block SHALL drive h_readyout=0, h_resp=1 and abort=1 for exactly one cycle, then go to ERR2 unconditionally.
REQ-008 In ERR2, the block SHALL drive h_readyout=1, h_resp=1 and abort=1 for exactly one cycle, giving the AHB two-cycle ERROR response.
REQ-009 On leaving ERR2, the block SHALL go to FLUSH if h_trans is SEQ or BUSY; otherwise it SHALL go to IDLE.
REQ-010 In FLUSH, the block SHALL drive h_readyout=1, h_resp=0 and abort=1, so that remaining beats complete zero-wait and OKAY with no APB access.
REQ-011 In FLUSH, h_trans of IDLE or NONSEQ sampled with h_ready=1 SHALL return the FSM to IDLE.
REQ-012 In FLUSH, burst_err=1 SHALL take priority over the exit condition and go to ERR1.
REQ-013 burst_err SHALL be ignored while the FSM is in HOLD, ERR1 or ERR2; no second response SHALL be queued.
REQ-014 On the ERR1 entry edge, err_addr SHALL load reg_addr, and err_cnt SHALL increment by 1, saturating at 8'hFF.
REQ-015 err_clr=1 SHALL zero err_cnt and err_addr on the next edge; if err_clr and an ERR1 entry coincide, err_clr wins and the count becomes 0.
REQ-016 All outputs SHALL be decoded from registered state only, with no combinational path from burst_err to h_resp; the exception is h_readyout in IDLE, which follows apb_ready.
REQ-017 Error-response latency SHALL be as follows: burst_err high at edge N with apb_ready=1 gives h_resp=1 during cycles N+1 and N+2.

Reset
REQ-018 When h_resetn=0, the FSM SHALL go to IDLE immediately and asynchronously, and err_addr and err_cnt SHALL clear to 0.
REQ-019 During reset, the outputs SHALL be h_readyout=apb_ready, h_resp=0 and abort=0.
REQ-020 Reset asserted in any state, including mid-ERR1 or mid-ERR2, SHALL abandon the response with no partial ERROR cycle after release.

Structure
REQ-021 The HTRANS encodings, the HRESP encodings and the FSM state enum SHALL reside in the shared package ahb_bridge_pkg.
REQ-022 err_addr and err_cnt SHALL be implemented in a sub-module named err_log, which takes a load strobe and err_clr.
REQ-023 The FSM and output decode SHALL stay in ahb_err_resp.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- burst_err pulse in IDLE with apb_ready=1 -> h_readyout 0 then 1, h_resp 1,1, abort high for 2 cycles, err_cnt=1.
- burst_err with apb_ready=0 for 3 cycles -> HOLD for 3 cycles with h_resp=0, then the two-cycle ERROR response.
- Error on beat 2 of INCR4 at reg_addr=32'h0000_1004, master continues with SEQ -> err_addr=32'h0000_1004; remaining beats OKAY with abort=1; NONSEQ returns the FSM to IDLE.
- burst_err pulsed 256 times -> err_cnt saturates at 8'hFF; err_clr coincident with an error -> err_cnt=0.
- burst_err held high during ERR1 and ERR2 -> exactly one two-cycle response.
- burst_err held high in FLUSH -> ERR1 re-entered; err_cnt increments.
- h_resetn dropped during ERR1 -> h_resp=0 at once; IDLE after release; err_cnt=0.
